// File: rtl/dbg_pkg.sv
// Shared constants for the debug command bridge: command and reply bytes, FSM states.
// The 'N' command byte only exists when DBG_BRIDGE_AUTOINC_EN is defined.
package dbg_pkg;

  localparam logic [7:0] CMD_HALT  = 8'h48;  // 'H'
  localparam logic [7:0] CMD_GO    = 8'h47;  // 'G'
  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_PC    = 8'h50;  // 'P'
`ifdef DBG_BRIDGE_AUTOINC_EN
  localparam logic [7:0] CMD_NEXT  = 8'h4E;  // 'N'
`endif

  localparam logic [7:0] RSP_OK    = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR   = 8'h45;  // 'E'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_MEM,
    ST_RDWAIT,
    ST_TX
  } state_e;

endpackage

// File: rtl/dbg_shift32.sv
// Four-byte register: assembles LSB-first bytes, or loads a word and serialises it LSB-first.
module dbg_shift32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        shift_in,
  input  logic [7:0]  in_byte,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        shift_out,
  output logic [31:0] word
);

  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
    end else if (load) begin
      word <= load_word;
    end else if (shift_in) begin
      word <= {in_byte, word[31:8]};
    end else if (shift_out) begin
      word <= {8'h00, word[31:8]};
    end
  end

endmodule

// File: rtl/dbg_cmd_bridge.sv
// Byte-stream debug command decoder driving the debug memory port and the CPU halt line.
// Define DBG_BRIDGE_AUTOINC_EN to add the 'N' (store to previous address + 4) command.
module dbg_cmd_bridge
  import dbg_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 1_000_000,
  parameter logic [1:0] WORD_SEL    = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        debug,
  output logic        mem_en_dbg,
  output logic        mem_we_dbg,
  output logic [31:0] mem_addr_dbg,
  output logic [31:0] mem_wdata_dbg,
  output logic [1:0]  mem_byte_sel_dbg,
  input  logic [31:0] mem_rdata_dbg,
  input  logic [31:0] pc
);

  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYC - 1);

  state_e      state;
  logic [7:0]  cmd;
  logic [1:0]  byte_cnt;
  logic [19:0] timer;
  logic [1:0]  rply_left;
  logic        pc_pend;

  logic        rx_fire;
  logic        tx_fire;
  logic [31:0] addr_word;
  logic [31:0] data_word;
  logic [31:0] addr_next;
  logic [31:0] data_next;
  logic [31:0] wr_addr;
  logic        rply_load;
  logic [31:0] rply_word;

  assign rx_ready  = !rst && (state == ST_IDLE || state == ST_ADDR || state == ST_DATA);
  assign rx_fire   = rx_valid && rx_ready;
  assign tx_fire   = tx_valid && tx_ready;
  assign addr_next = {rx_data, addr_word[31:8]};
  assign data_next = {rx_data, data_word[31:8]};
  assign tx_data   = data_word[7:0];

`ifdef DBG_BRIDGE_AUTOINC_EN
  logic [31:0] base_addr;
  assign wr_addr = (cmd == CMD_NEXT) ? base_addr + 32'd4 : addr_word;
`else
  assign wr_addr = addr_word;
`endif

  dbg_shift32 u_addr (
    .clk       (clk),
    .rst       (rst),
    .shift_in  (rx_fire && state == ST_ADDR),
    .in_byte   (rx_data),
    .load      (1'b0),
    .load_word (32'h0),
    .shift_out (1'b0),
    .word      (addr_word)
  );

  // Write data is assembled here and the same register later serialises the reply.
  dbg_shift32 u_data (
    .clk       (clk),
    .rst       (rst),
    .shift_in  (rx_fire && state == ST_DATA),
    .in_byte   (rx_data),
    .load      (rply_load),
    .load_word (rply_word),
    .shift_out (tx_fire && state == ST_TX && rply_left != 2'd0),
    .word      (data_word)
  );

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    rply_load = 1'b0;
    rply_word = 32'h0;
    case (state)
      ST_IDLE: begin
        if (rx_fire && (rx_data == CMD_HALT || rx_data == CMD_GO)) begin
          rply_load = 1'b1;
          rply_word = {24'h0, RSP_OK};
        end
      end
      ST_MEM: begin
        if (!(cmd == CMD_READ && debug)) begin
          rply_load = 1'b1;
          rply_word = {24'h0, debug ? RSP_OK : RSP_ERR};
        end
      end
      ST_RDWAIT: begin
        rply_load = 1'b1;
        rply_word = mem_rdata_dbg;
      end
      ST_TX: begin
        if (pc_pend) begin
          rply_load = 1'b1;
          rply_word = pc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      cmd              <= '0;
      byte_cnt         <= '0;
      timer            <= '0;
      rply_left        <= '0;
      pc_pend          <= 1'b0;
      debug            <= 1'b1;
      mem_en_dbg       <= 1'b0;
      mem_we_dbg       <= 1'b0;
      mem_addr_dbg     <= '0;
      mem_wdata_dbg    <= '0;
      mem_byte_sel_dbg <= '0;
      tx_valid         <= 1'b0;
`ifdef DBG_BRIDGE_AUTOINC_EN
      base_addr        <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments; the later assignment in the case below overrides this pulse default.
      mem_en_dbg       <= 1'b0;
      mem_we_dbg       <= 1'b0;
      mem_byte_sel_dbg <= WORD_SEL;
      case (state)
        ST_IDLE: begin
          byte_cnt <= '0;
          timer    <= '0;
          if (rx_fire) begin
            cmd <= rx_data;
            case (rx_data)
              CMD_WRITE, CMD_READ: state <= ST_ADDR;
`ifdef DBG_BRIDGE_AUTOINC_EN
              CMD_NEXT: state <= ST_DATA;
`endif
              CMD_HALT: begin
                debug     <= 1'b1;
                tx_valid  <= 1'b1;
                rply_left <= 2'd0;
                state     <= ST_TX;
              end
              CMD_GO: begin
                debug     <= 1'b0;
                tx_valid  <= 1'b1;
                rply_left <= 2'd0;
                state     <= ST_TX;
              end
              CMD_PC: begin
                pc_pend   <= 1'b1;
                rply_left <= 2'd3;
                state     <= ST_TX;
              end
              default: ;
            endcase
          end
        end

        ST_ADDR, ST_DATA: begin
          if (rx_fire) begin
            timer    <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (state == ST_ADDR && cmd == CMD_WRITE) begin
                state <= ST_DATA;
              end else begin
                // Not halted: arguments are swallowed but the strobe is suppressed.
                state      <= ST_MEM;
                mem_en_dbg <= debug;
                mem_we_dbg <= debug && (state == ST_DATA);
                if (debug) begin
                  if (state == ST_ADDR) begin
                    mem_addr_dbg <= addr_next;
                  end else begin
                    mem_addr_dbg  <= wr_addr;
                    mem_wdata_dbg <= data_next;
`ifdef DBG_BRIDGE_AUTOINC_EN
                    base_addr     <= wr_addr;
`endif
                  end
                end
              end
            end
          end else if (timer == TMO_LAST) begin
            state <= ST_IDLE;
          end else begin
            timer <= timer + 20'd1;
          end
        end

        ST_MEM: begin
          if (cmd == CMD_READ && debug) begin
            state <= ST_RDWAIT;
          end else begin
            tx_valid  <= 1'b1;
            rply_left <= 2'd0;
            state     <= ST_TX;
          end
        end

        ST_RDWAIT: begin
          tx_valid  <= 1'b1;
          rply_left <= 2'd3;
          state     <= ST_TX;
        end

        ST_TX: begin
          if (pc_pend) begin
            pc_pend  <= 1'b0;
            tx_valid <= 1'b1;
          end else if (tx_fire) begin
            if (rply_left == 2'd0) begin
              tx_valid <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              rply_left <= rply_left - 2'd1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_cmd_bridge.sv
// Self-checking bench for dbg_cmd_bridge: directed and randomized commands against a
// transaction-level model of the command set, plus a simple RAM on the debug port.
module tb_dbg_cmd_bridge;
  import dbg_pkg::*;

  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        debug;
  logic        mem_en_dbg;
  logic        mem_we_dbg;
  logic [31:0] mem_addr_dbg;
  logic [31:0] mem_wdata_dbg;
  logic [1:0]  mem_byte_sel_dbg;
  logic [31:0] mem_rdata_dbg = 32'h0;
  logic [31:0] pc = 32'h0;

  always #5 clk = ~clk;

  dbg_cmd_bridge #(.TIMEOUT_CYC(TMO), .WORD_SEL(2'b10)) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_valid         (rx_valid),
    .rx_data          (rx_data),
    .rx_ready         (rx_ready),
    .tx_valid         (tx_valid),
    .tx_data          (tx_data),
    .tx_ready         (tx_ready),
    .debug            (debug),
    .mem_en_dbg       (mem_en_dbg),
    .mem_we_dbg       (mem_we_dbg),
    .mem_addr_dbg     (mem_addr_dbg),
    .mem_wdata_dbg    (mem_wdata_dbg),
    .mem_byte_sel_dbg (mem_byte_sel_dbg),
    .mem_rdata_dbg    (mem_rdata_dbg),
    .pc               (pc)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // RAM on the debug port plus a log of every strobe seen.
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } strobe_t;

  logic [31:0] ram [int unsigned];
  strobe_t     obs_q[$];

  always @(posedge clk) begin
    if (!rst && mem_en_dbg) begin
      obs_q.push_back('{we: mem_we_dbg, addr: mem_addr_dbg, wdata: mem_wdata_dbg});
      if (mem_we_dbg) ram[mem_addr_dbg] = mem_wdata_dbg;
      else mem_rdata_dbg <= ram.exists(mem_addr_dbg) ? ram[mem_addr_dbg] : 32'h0;
    end
  end

  // Reference model of the command set.
  bit          halted;
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] last_wr;
  logic [31:0] wr_list[$];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic recv(input logic [7:0] exp);
    int n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("tx_valid", 32'(tx_valid), 32'd1);
    check("tx_data", 32'(tx_data), 32'(exp));
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic check_strobes(input strobe_t exp_s[$]);
    check("strobe_count", 32'(obs_q.size()), 32'(exp_s.size()));
    for (int i = 0; i < exp_s.size() && i < obs_q.size(); i++) begin
      check("strobe_we", 32'(obs_q[i].we), 32'(exp_s[i].we));
      check("strobe_addr", obs_q[i].addr, exp_s[i].addr);
      if (exp_s[i].we) check("strobe_wdata", obs_q[i].wdata, exp_s[i].wdata);
    end
    obs_q.delete();
  endtask

  // One full command: model prediction, stimulus, timing checks, reply and strobe comparison.
  task automatic run_cmd(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                         input int gap, input bit stall);
    logic [7:0]  rep[$];
    strobe_t     exp_s[$];
    logic [31:0] ea;
    logic [31:0] rw;
    bit is_wr, is_rd, is_nx, is_mem;
    is_wr = (c == 8'h57);
    is_rd = (c == 8'h52);
    is_nx = 1'b0;
`ifdef DBG_BRIDGE_AUTOINC_EN
    is_nx = (c == 8'h4E);
`endif
    is_mem = is_wr || is_rd || is_nx;
    ea = is_nx ? last_wr + 32'd4 : a;

    if (c == 8'h48) begin halted = 1'b1; rep.push_back(8'h4B); end
    else if (c == 8'h47) begin halted = 1'b0; rep.push_back(8'h4B); end
    else if (c == 8'h50) begin
      for (int i = 0; i < 4; i++) rep.push_back(pc[8*i +: 8]);
    end else if (is_mem) begin
      if (!halted) rep.push_back(8'h45);
      else if (is_rd) begin
        rw = ref_rd(ea);
        exp_s.push_back('{we: 1'b0, addr: ea, wdata: 32'h0});
        for (int i = 0; i < 4; i++) rep.push_back(rw[8*i +: 8]);
      end else begin
        exp_s.push_back('{we: 1'b1, addr: ea, wdata: d});
        ref_mem[ea] = d;
        last_wr = ea;
        wr_list.push_back(ea);
        rep.push_back(8'h4B);
      end
    end

    send(c);
    if (is_wr || is_rd) begin
      for (int i = 0; i < 4; i++) begin
        send(a[8*i +: 8]);
        if (i == 1 && gap > 0) repeat (gap) @(negedge clk);
      end
    end
    if (is_wr || is_nx) for (int i = 0; i < 4; i++) send(d[8*i +: 8]);

    if (is_mem) begin
      check("strobe_t1", 32'(mem_en_dbg), 32'(halted));
      check("we_t1", 32'(mem_we_dbg), 32'(halted && !is_rd));
      if (halted) check("addr_t1", mem_addr_dbg, ea);
      @(negedge clk);
      check("strobe_t2", 32'(mem_en_dbg), 32'd0);
      check("tx_valid_t2", 32'(tx_valid), 32'(!(halted && is_rd)));
      if (halted && is_rd) begin
        @(negedge clk);
        check("tx_valid_t3", 32'(tx_valid), 32'd1);
      end
    end else if (c == 8'h48 || c == 8'h47) begin
      check("debug_after", 32'(debug), 32'(halted));
    end else if (c == 8'h50) begin
      @(negedge clk);
      pc = ~pc;  // past the sample point: must not affect the reply
    end

    for (int i = 0; i < rep.size(); i++) begin
      if (stall && i == 1) begin
        repeat (10) begin
          @(negedge clk);
          check("stall_valid", 32'(tx_valid), 32'd1);
          check("stall_data", 32'(tx_data), 32'(rep[1]));
        end
      end
      recv(rep[i]);
    end
    repeat (3) @(negedge clk);
    check("no_extra_tx", 32'(tx_valid), 32'd0);
    check("idle_ready", 32'(rx_ready), 32'd1);
    check_strobes(exp_s);
  endtask

  function automatic logic [7:0] junk_byte();
    logic [7:0] b;
    do b = 8'($urandom);
    while (b inside {8'h48, 8'h47, 8'h57, 8'h52, 8'h50, 8'h4E});
    return b;
  endfunction

  initial begin
    strobe_t none[$];
    logic [31:0] ra;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_debug", 32'(debug), 32'd1);
    check("rst_mem_en", 32'(mem_en_dbg), 32'd0);
    check("rst_mem_we", 32'(mem_we_dbg), 32'd0);
    check("rst_addr", mem_addr_dbg, 32'h0);
    check("rst_wdata", mem_wdata_dbg, 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_byte_sel", 32'(mem_byte_sel_dbg), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("byte_sel", 32'(mem_byte_sel_dbg), 32'd2);
    check("idle_rx_ready", 32'(rx_ready), 32'd1);
    halted  = 1'b1;
    last_wr = 32'h0;

`ifdef DBG_BRIDGE_AUTOINC_EN
    // 'N' before any 'W' stores to 0x4
    run_cmd(8'h4E, 32'h0, 32'hCAFE0004, 0, 1'b0);
`else
    // 'N' is just an unknown byte here
    run_cmd(8'h4E, 32'h0, 32'h0, 0, 1'b0);
`endif

    run_cmd(8'h57, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0);
    run_cmd(8'h52, 32'h0000_0010, 32'h0, 0, 1'b0);
`ifdef DBG_BRIDGE_AUTOINC_EN
    run_cmd(8'h57, 32'h0000_0020, 32'h5555_AAAA, 0, 1'b0);
    run_cmd(8'h4E, 32'h0, 32'h1122_3344, 0, 1'b0);
    run_cmd(8'h57, 32'hFFFF_FFFC, 32'h0BAD_F00D, 0, 1'b0);
    run_cmd(8'h4E, 32'h0, 32'h7777_0000, 0, 1'b0);
`endif

    pc = 32'h0000_0104;
    run_cmd(8'h50, 32'h0, 32'h0, 0, 1'b0);

    // Halt interlock
    run_cmd(8'h47, 32'h0, 32'h0, 0, 1'b0);
    run_cmd(8'h57, 32'h0000_0040, 32'h1234_5678, 0, 1'b0);
    run_cmd(8'h52, 32'h0000_0010, 32'h0, 0, 1'b0);
    run_cmd(8'h48, 32'h0, 32'h0, 0, 1'b0);

    // Unknown bytes, unaligned address, stalled reply, inter-byte gap just under the timeout
    repeat (3) run_cmd(junk_byte(), 32'h0, 32'h0, 0, 1'b0);
    run_cmd(8'h57, 32'h0000_0103, 32'hA5A5_0103, 0, 1'b0);
    run_cmd(8'h52, 32'h0000_0103, 32'h0, 0, 1'b1);
    run_cmd(8'h52, 32'h0000_0010, 32'h0, TMO - 10, 1'b0);

    // Timeout mid-frame, then 'P' must be decoded as a command
    send(8'h52);
    send(8'h10);
    send(8'h00);
    repeat (TMO + 5) @(negedge clk);
    check("tmo_tx_valid", 32'(tx_valid), 32'd0);
    check_strobes(none);
    pc = $urandom;
    run_cmd(8'h50, 32'h0, 32'h0, 0, 1'b0);

    // Randomized command mix
    for (int i = 0; i < 24; i++) begin
      int op;
      op = $urandom_range(0, 6);
      case (op)
        0, 1: run_cmd(8'h57, $urandom, $urandom, 0, 1'b0);
        2, 3: begin
          if (wr_list.size() > 0 && $urandom_range(0, 3) != 0)
            ra = wr_list[$urandom_range(0, wr_list.size() - 1)];
          else
            ra = $urandom;
          run_cmd(8'h52, ra, 32'h0, 0, 1'($urandom_range(0, 1)));
        end
        4: begin pc = $urandom; run_cmd(8'h50, 32'h0, 32'h0, 0, 1'b0); end
        5: run_cmd(halted ? 8'h47 : 8'h48, 32'h0, 32'h0, 0, 1'b0);
        default: run_cmd(junk_byte(), 32'h0, 32'h0, 0, 1'b0);
      endcase
    end

    // Reset mid-frame while running: frame dropped, CPU halted again
    run_cmd(8'h47, 32'h0, 32'h0, 0, 1'b0);
    send(8'h57);
    send(8'h80);
    send(8'h00);
    send(8'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    halted  = 1'b1;
    last_wr = 32'h0;
    check("rst2_debug", 32'(debug), 32'd1);
    check("rst2_tx_valid", 32'(tx_valid), 32'd0);
    check("rst2_mem_en", 32'(mem_en_dbg), 32'd0);
    check_strobes(none);
`ifdef DBG_BRIDGE_AUTOINC_EN
    run_cmd(8'h4E, 32'h0, 32'h0404_0404, 0, 1'b0);
`endif
    run_cmd(8'h52, 32'h0000_0010, 32'h0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dbg_cmd_bridge.md
# dbg_cmd_bridge

Byte-stream debug command decoder that drives the top-level debug memory port and CPU halt line. Sits directly upstream of the SoC top: consumes bytes from an external serial receiver, issues single-word loads/stores on the debug memory interface and controls `debug` (halt), and returns responses on a byte-stream transmit port. Used to load programs into RAM, inspect memory and read the PC with the CPU halted.

## Interface
- `TIMEOUT_CYC`, 1_000_000: idle cycles mid-command before the frame is abandoned.
- `WORD_SEL`, 2'b10: `mem_byte_sel_dbg` encoding for a 32-bit word access.
- `clk` in 1: single clock for the whole block.
- `rst` in 1: synchronous, active-high reset.
- `rx_valid` in 1: `rx_data` holds a received byte.
- `rx_data` in 8: received byte.
- `rx_ready` out 1: bridge accepts the byte this cycle.
- `tx_valid` out 1: `tx_data` holds a response byte.
- `tx_data` out 8: response byte.
- `tx_ready` in 1: transmitter accepts the byte this cycle.
- `debug` out 1: halts the CPU and hands the memory port to the bridge.
- `mem_en_dbg` out 1: memory access strobe.
- `mem_we_dbg` out 1: write enable, qualified by `mem_en_dbg`.
- `mem_addr_dbg` out 32: byte address.
- `mem_wdata_dbg` out 32: write data.
- `mem_byte_sel_dbg` out 2: access size, always `WORD_SEL`.
- `mem_rdata_dbg` in 32: read data, valid one cycle after a read strobe.
- `pc` in 32: current CPU program counter.

## Operation
- Byte handshake: transfer when `valid && ready`; `tx_data` held stable while `tx_valid` is high.
- Multi-byte fields are little-endian (LSB first).
- Commands (first byte):
  - `'H'` (0x48): `debug`<=1, reply `'K'`.
  - `'G'` (0x47): `debug`<=0, reply `'K'`.
  - `'W'` (0x57) + 4 address bytes + 4 data bytes: word store, reply `'K'`.
  - `'R'` (0x52) + 4 address bytes: word load, reply 4 data bytes.
  - `'P'` (0x50): reply 4 bytes of `pc`, sampled the cycle after the command byte is accepted.
  - Any other byte: silently dropped, remain in IDLE.
- `'W'`/`'R'` received while `debug`=0: all argument bytes consumed, no memory strobe, reply `'E'` (0x45).
- Address low 2 bits passed through unmodified; alignment is the RAM's concern.
- FSM states: IDLE, ADDR (4 bytes), DATA (4 bytes), MEM, RDWAIT, TX.
  - IDLE -> ADDR on `'W'`/`'R'`; IDLE -> TX on `'H'`/`'G'`/`'P'`.
  - ADDR -> DATA (`'W'`) or MEM (`'R'`) after 4th byte; DATA -> MEM after 4th byte.
  - MEM -> TX (write or error) or RDWAIT (read); RDWAIT -> TX; TX -> IDLE after last reply byte transfers.
- `rx_ready`=1 only in IDLE, ADDR, DATA.
- Timeout: 20-bit counter clears on every accepted byte, counts in ADDR/DATA; reaching `TIMEOUT_CYC` -> IDLE, no reply, no memory access.

## Timing
- Reset values: `debug`=1 (CPU halted for program load), all other outputs 0, state IDLE.
- Last argument byte accepted in cycle t: `mem_en_dbg` high in t+1 only (exactly one cycle); `mem_we_dbg`=1 for `'W'`.
- Write: `tx_valid` with `'K'` from t+2.
- Read: `mem_rdata_dbg` captured at end of t+2; first reply byte valid from t+3.
- `mem_addr_dbg`, `mem_wdata_dbg` hold last values outside the strobe; `mem_byte_sel_dbg` is constant `WORD_SEL` after reset.
- `'H'`/`'G'`: `debug` changes in the cycle after the command byte is accepted.
- `tx_ready` low stalls TX indefinitely; no timeout in TX.
- `rst` mid-command: frame discarded, in-flight strobe cancelled, `debug` returns to 1.

## Configuration
- `DBG_BRIDGE_AUTOINC_EN` defined: adds `'N'` (0x4E) + 4 data bytes, storing to the last `'W'`/`'N'` address + 4 (32-bit wrap-around 0xFFFFFFFC -> 0x00000000), reply `'K'`. Before any `'W'` since reset the base is 0, so the first `'N'` writes 0x00000004. Halt check as for `'W'`.
- Not defined: `'N'` is an unknown command and is dropped; no address register retained.

## Structure
- Shared package `dbg_pkg`: command byte constants, reply constants `'K'`/`'E'`, FSM state enum.
- One natural sub-module: `dbg_shift32`, a 4-byte LSB-first assemble/serialise register, instantiated for address, write data and reply data.

## Test plan
- `'W'` addr 0x00000010 data 0xDEADBEEF, then `'R'` 0x00000010 -> one write strobe, reply `'K'`, then bytes EF BE AD DE.
- After reset, `'G'` then `'W'` -> `debug` falls, 8 argument bytes consumed, no strobe, reply `'E'`; `'H'` -> `debug` high, `'K'`.
- `'P'` with `pc`=0x00000104 -> reply 04 01 00 00.
- `'R'` + 2 address bytes, then `TIMEOUT_CYC` idle cycles, then `'P'` -> no strobe, only the `'P'` reply.
- `tx_ready` held low 10 cycles during a read reply -> `tx_data` stable, no bytes lost or repeated.
- With `DBG_BRIDGE_AUTOINC_EN`: `'W'` 0x00000020, then `'N'` 0x11223344 -> second strobe at 0x00000024 with data 0x11223344.
